// File: rtl/risc16_mem_requester.sv
// Request sequencer between the RiSC16 load/store datapath and the single-port
// word memory. One load or store is accepted at a time. The block drives the
// memory address/data/write-enable, waits out the memory read latency, and
// returns read data, a store acknowledgement or an address error over a
// response handshake.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   reqValid/reqReady                request handshake (reqReady combinational)
//   reqWrite, reqAddr, reqData       request payload (1 = store)
//   respValid/respReady              response handshake
//   respData, respErr                load data (0 for stores/errors), range error
//   memAddress, memDataIn,
//   memWriteEn                       registered memory-side controls
//   memDataOut                       memory read data
module risc16_mem_requester #(
    parameter int unsigned WORD_LENGTH  = 16,
    parameter int unsigned MEM_SIZE     = 65536,
    parameter int unsigned READ_LATENCY = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   reqValid,
    output logic                   reqReady,
    input  logic                   reqWrite,
    input  logic [WORD_LENGTH-1:0] reqAddr,
    input  logic [WORD_LENGTH-1:0] reqData,
    output logic                   respValid,
    input  logic                   respReady,
    output logic [WORD_LENGTH-1:0] respData,
    output logic                   respErr,
    output logic [WORD_LENGTH-1:0] memAddress,
    output logic [WORD_LENGTH-1:0] memDataIn,
    output logic                   memWriteEn,
    input  logic [WORD_LENGTH-1:0] memDataOut
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned CMP_W = 33;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(READ_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [WORD_LENGTH-1:0] addr_nxt;
    logic [WORD_LENGTH-1:0] din_nxt;
    logic [WORD_LENGTH-1:0] rdata_nxt;
    logic                   we_nxt;
    logic                   rvalid_nxt;
    logic                   rerr_nxt;
    logic                   in_range_c;

    // Request acceptance: only in IDLE and never while reset is asserted.
    assign reqReady = (state == IDLE) && !rst;

    // Unsigned range check, widened so MEM_SIZE = 2**WORD_LENGTH is representable.
    assign in_range_c = (CMP_W'(reqAddr) < CMP_W'(MEM_SIZE));

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        addr_nxt   = memAddress;
        din_nxt    = memDataIn;
        we_nxt     = 1'b0;
        rvalid_nxt = respValid;
        rdata_nxt  = respData;
        rerr_nxt   = respErr;

        case (state)
            IDLE: begin
                if (reqValid) begin
                    if (!in_range_c) begin
                        // No memory access; the error response follows one cycle later.
                        rerr_nxt  = 1'b1;
                        rdata_nxt = '0;
                        state_nxt = RESP;
                    end else if (reqWrite) begin
                        addr_nxt  = reqAddr;
                        din_nxt   = reqData;
                        we_nxt    = 1'b1;
                        state_nxt = WRITE;
                    end else begin
                        addr_nxt  = reqAddr;
                        cnt_nxt   = '0;
                        state_nxt = READ;
                    end
                end
            end

            WRITE: begin
                // Memory commits at the edge ending this cycle.
                rvalid_nxt = 1'b1;
                rdata_nxt  = '0;
                rerr_nxt   = 1'b0;
                state_nxt  = RESP;
            end

            READ: begin
                if (cnt == LAT_LAST) begin
                    rdata_nxt  = memDataOut;
                    rvalid_nxt = 1'b1;
                    rerr_nxt   = 1'b0;
                    state_nxt  = RESP;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end

            RESP: begin
                if (!respValid) begin
                    // Error path enters RESP with respValid low; raise it here.
                    rvalid_nxt = 1'b1;
                end else if (respReady) begin
                    rvalid_nxt = 1'b0;
                    rerr_nxt   = 1'b0;
                    state_nxt  = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            memAddress <= '0;
            memDataIn  <= '0;
            memWriteEn <= 1'b0;
            respValid  <= 1'b0;
            respData   <= '0;
            respErr    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            memAddress <= addr_nxt;
            memDataIn  <= din_nxt;
            memWriteEn <= we_nxt;
            respValid  <= rvalid_nxt;
            respData   <= rdata_nxt;
            respErr    <= rerr_nxt;
        end
    end

endmodule

// File: tb/tb_risc16_mem_requester.sv
// Bench for risc16_mem_requester. Three instances with different memory size
// and read latency run side by side against a transaction-level reference
// model (request accepted -> response due after a fixed latency -> held until
// taken) and a behavioural memory with configurable read latency.
module tb_risc16_mem_requester;

    localparam int NCFG      = 3;
    localparam int W         = 16;
    localparam int NCYC_RAND = 3000;

    function automatic int unsigned rl_of(input int g);
        case (g)
            0:       return 0;
            1:       return 3;
            default: return 7;
        endcase
    endfunction

    function automatic int unsigned ms_of(input int g);
        case (g)
            0:       return 65536;
            1:       return 4096;
            default: return 32768;
        endcase
    endfunction

    function automatic logic [W-1:0] init_val(input int a);
        return W'((a * 40503) ^ 23130);
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NCFG-1:0]        rst, reqValid, reqWrite, respReady;
    logic [NCFG-1:0]        reqReady, respValid, respErr, memWriteEn;
    logic [NCFG-1:0][W-1:0] reqAddr, reqData, respData, memAddress, memDataIn, memDataOut;

    for (genvar gi = 0; gi < NCFG; gi++) begin : cfg
        risc16_mem_requester #(
            .WORD_LENGTH (W),
            .MEM_SIZE    (ms_of(gi)),
            .READ_LATENCY(rl_of(gi))
        ) dut (
            .clk       (clk),
            .rst       (rst[gi]),
            .reqValid  (reqValid[gi]),
            .reqReady  (reqReady[gi]),
            .reqWrite  (reqWrite[gi]),
            .reqAddr   (reqAddr[gi]),
            .reqData   (reqData[gi]),
            .respValid (respValid[gi]),
            .respReady (respReady[gi]),
            .respData  (respData[gi]),
            .respErr   (respErr[gi]),
            .memAddress(memAddress[gi]),
            .memDataIn (memDataIn[gi]),
            .memWriteEn(memWriteEn[gi]),
            .memDataOut(memDataOut[gi])
        );
    end

    // Environment memory (driven by DUT outputs) and the model's own view of memory.
    logic [W-1:0] mem     [NCFG][65536];
    logic [W-1:0] ref_mem [NCFG][65536];
    logic [W-1:0] hist    [NCFG][8];

    // Reference model state.
    bit           m_busy [NCFG];
    bit           m_rv   [NCFG];
    bit           m_re   [NCFG];
    bit           m_we   [NCFG];
    bit           m_rd   [NCFG];
    bit           p_err  [NCFG];
    int           m_wait [NCFG];
    logic [W-1:0] m_rdata[NCFG];
    logic [W-1:0] m_addr [NCFG];
    logic [W-1:0] m_din  [NCFG];
    logic [W-1:0] p_data [NCFG];

    int checks;
    int errors;

    task automatic chk(input int g, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h (t=%0t)", g, name, act, exp, $time);
        end
    endtask

    // Advance the model across the coming clock edge using the inputs now applied.
    task automatic model_step(input int g);
        if (rst[g]) begin
            m_busy[g] = 1'b0;
            m_rv[g]   = 1'b0;
            m_we[g]   = 1'b0;
            m_rd[g]   = 1'b0;
            m_wait[g] = 0;
        end else if (!m_busy[g]) begin
            if (reqValid[g]) begin
                m_busy[g] = 1'b1;
                if (32'(reqAddr[g]) >= ms_of(g)) begin
                    p_err[g]  = 1'b1;
                    p_data[g] = '0;
                    m_wait[g] = 1;
                end else if (reqWrite[g]) begin
                    m_addr[g] = reqAddr[g];
                    m_din[g]  = reqData[g];
                    m_we[g]   = 1'b1;
                    ref_mem[g][reqAddr[g]] = reqData[g];
                    p_err[g]  = 1'b0;
                    p_data[g] = '0;
                    m_wait[g] = 1;
                end else begin
                    m_addr[g] = reqAddr[g];
                    m_rd[g]   = 1'b1;
                    p_err[g]  = 1'b0;
                    p_data[g] = ref_mem[g][reqAddr[g]];
                    m_wait[g] = int'(rl_of(g)) + 1;
                end
            end
        end else if (m_rv[g]) begin
            if (respReady[g]) begin
                m_rv[g]   = 1'b0;
                m_busy[g] = 1'b0;
            end
        end else begin
            m_wait[g] = m_wait[g] - 1;
            m_we[g]   = 1'b0;
            if (m_wait[g] == 0) begin
                m_rv[g]    = 1'b1;
                m_rd[g]    = 1'b0;
                m_rdata[g] = p_data[g];
                m_re[g]    = p_err[g];
            end
        end
    endtask

    // Memory with READ_LATENCY-cycle read delay; a write seen during a cycle commits at its closing edge.
    task automatic env_mem(input int g);
        for (int k = 7; k > 0; k--) hist[g][k] = hist[g][k-1];
        hist[g][0] = memAddress[g];
        memDataOut[g] = mem[g][hist[g][rl_of(g)]];
        if (memWriteEn[g]) mem[g][memAddress[g]] = memDataIn[g];
    endtask

    task automatic compare(input int g);
        chk(g, "reqReady", 32'(reqReady[g]), 32'(!rst[g] && !m_busy[g]));
        chk(g, "respValid", 32'(respValid[g]), 32'(m_rv[g]));
        if (m_rv[g]) begin
            chk(g, "respData", 32'(respData[g]), 32'(m_rdata[g]));
            chk(g, "respErr", 32'(respErr[g]), 32'(m_re[g]));
        end
        chk(g, "memWriteEn", 32'(memWriteEn[g]), 32'(m_we[g]));
        if (m_we[g]) begin
            chk(g, "wr_memAddress", 32'(memAddress[g]), 32'(m_addr[g]));
            chk(g, "wr_memDataIn", 32'(memDataIn[g]), 32'(m_din[g]));
        end
        if (m_rd[g]) chk(g, "rd_memAddress", 32'(memAddress[g]), 32'(m_addr[g]));
    endtask

    task automatic cycle();
        for (int g = 0; g < NCFG; g++) model_step(g);
        @(negedge clk);
        for (int g = 0; g < NCFG; g++) begin
            env_mem(g);
            compare(g);
        end
    endtask

    task automatic drive(input logic v, input logic wr, input logic [W-1:0] a, input logic [W-1:0] d);
        reqValid = {NCFG{v}};
        reqWrite = {NCFG{wr}};
        for (int g = 0; g < NCFG; g++) begin
            reqAddr[g] = a;
            reqData[g] = d;
        end
    endtask

    task automatic ack();
        respReady = '1;
        cycle();
        for (int g = 0; g < NCFG; g++) begin
            chk(g, "ack_respValid", 32'(respValid[g]), 32'd0);
            chk(g, "ack_reqReady", 32'(reqReady[g]), 32'd1);
        end
        respReady = '0;
    endtask

    function automatic logic [W-1:0] pick_addr();
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return W'($urandom_range(0, 15));
            6:                return 16'h0FFF;
            7:                return 16'h1000;
            8:                return ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
            default:          return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] oor [2];
        int           first [NCFG];

        checks = 0;
        errors = 0;
        for (int g = 0; g < NCFG; g++) begin
            for (int a = 0; a < 65536; a++) begin
                mem[g][a]     = init_val(a);
                ref_mem[g][a] = init_val(a);
            end
            for (int k = 0; k < 8; k++) hist[g][k] = '0;
            m_busy[g] = 1'b0; m_rv[g] = 1'b0; m_re[g] = 1'b0; m_we[g] = 1'b0;
            m_rd[g] = 1'b0; p_err[g] = 1'b0; m_wait[g] = 0;
            m_rdata[g] = '0; m_addr[g] = '0; m_din[g] = '0; p_data[g] = '0;
        end
        rst        = '1;
        respReady  = '0;
        memDataOut = '0;
        drive(1'b0, 1'b0, '0, '0);

        // Reset values
        cycle();
        cycle();
        for (int g = 0; g < NCFG; g++) begin
            chk(g, "rst_reqReady", 32'(reqReady[g]), 32'd0);
            chk(g, "rst_respValid", 32'(respValid[g]), 32'd0);
            chk(g, "rst_memWriteEn", 32'(memWriteEn[g]), 32'd0);
            chk(g, "rst_memAddress", 32'(memAddress[g]), 32'd0);
            chk(g, "rst_memDataIn", 32'(memDataIn[g]), 32'd0);
            chk(g, "rst_respData", 32'(respData[g]), 32'd0);
            chk(g, "rst_respErr", 32'(respErr[g]), 32'd0);
        end
        rst = '0;
        cycle();
        for (int g = 0; g < NCFG; g++) chk(g, "post_rst_reqReady", 32'(reqReady[g]), 32'd1);

        // Store 0x2000 at 0x0222, then hold the ack for 5 cycles of backpressure
        drive(1'b1, 1'b1, 16'h0222, 16'h2000);
        cycle();
        drive(1'b0, 1'b0, '0, '0);
        for (int g = 0; g < NCFG; g++) begin
            chk(g, "st_memWriteEn", 32'(memWriteEn[g]), 32'd1);
            chk(g, "st_memAddress", 32'(memAddress[g]), 32'h0222);
            chk(g, "st_memDataIn", 32'(memDataIn[g]), 32'h2000);
        end
        cycle();
        for (int g = 0; g < NCFG; g++) begin
            chk(g, "st_we_drop", 32'(memWriteEn[g]), 32'd0);
            chk(g, "st_ack_valid", 32'(respValid[g]), 32'd1);
            chk(g, "st_ack_data", 32'(respData[g]), 32'd0);
            chk(g, "st_ack_err", 32'(respErr[g]), 32'd0);
        end
        repeat (5) begin
            cycle();
            for (int g = 0; g < NCFG; g++) begin
                chk(g, "bp_respValid", 32'(respValid[g]), 32'd1);
                chk(g, "bp_reqReady", 32'(reqReady[g]), 32'd0);
            end
        end
        ack();

        // Load 0x0222 with a store pulse to 0x0001 while busy; check latency and data
        drive(1'b1, 1'b0, 16'h0222, '0);
        cycle();
        drive(1'b1, 1'b1, 16'h0001, 16'hFFFF);
        for (int g = 0; g < NCFG; g++) first[g] = -1;
        for (int k = 1; k <= 9; k++) begin
            cycle();
            drive(1'b0, 1'b0, '0, '0);
            for (int g = 0; g < NCFG; g++) begin
                if (respValid[g] && first[g] < 0) first[g] = k;
                chk(g, "busy_memWriteEn", 32'(memWriteEn[g]), 32'd0);
            end
        end
        for (int g = 0; g < NCFG; g++) begin
            chk(g, "ld_latency", 32'(first[g]), rl_of(g) + 32'd1);
            chk(g, "ld_respData", 32'(respData[g]), 32'h2000);
        end
        ack();

        drive(1'b1, 1'b0, 16'h0001, '0);
        cycle();
        drive(1'b0, 1'b0, '0, '0);
        repeat (9) cycle();
        for (int g = 0; g < NCFG; g++)
            chk(g, "busy_unchanged", 32'(respData[g]), 32'(init_val(1)));
        ack();

        // Out-of-range stores, then a load at the top of the smallest memory
        oor[0] = 16'h1000;
        oor[1] = 16'h8000;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, oor[i], 16'hAAAA);
            cycle();
            drive(1'b0, 1'b0, '0, '0);
            for (int g = 0; g < NCFG; g++)
                chk(g, "oor_memWriteEn", 32'(memWriteEn[g]), 32'(32'(oor[i]) < ms_of(g)));
            cycle();
            for (int g = 0; g < NCFG; g++) begin
                chk(g, "oor_respValid", 32'(respValid[g]), 32'd1);
                chk(g, "oor_respErr", 32'(respErr[g]), 32'(32'(oor[i]) >= ms_of(g)));
                chk(g, "oor_respData", 32'(respData[g]), 32'd0);
            end
            ack();
        end
        drive(1'b1, 1'b0, 16'h0FFF, '0);
        cycle();
        drive(1'b0, 1'b0, '0, '0);
        repeat (9) cycle();
        for (int g = 0; g < NCFG; g++) begin
            chk(g, "top_respErr", 32'(respErr[g]), 32'd0);
            chk(g, "top_respData", 32'(respData[g]), 32'(init_val(32'h0FFF)));
        end
        ack();

        // Reset two cycles into a load: no response, outputs cleared
        drive(1'b1, 1'b0, 16'h0005, '0);
        cycle();
        drive(1'b0, 1'b0, '0, '0);
        cycle();
        rst = '1;
        cycle();
        for (int g = 0; g < NCFG; g++) begin
            chk(g, "abort_respValid", 32'(respValid[g]), 32'd0);
            chk(g, "abort_reqReady", 32'(reqReady[g]), 32'd0);
            chk(g, "abort_memWriteEn", 32'(memWriteEn[g]), 32'd0);
            chk(g, "abort_memAddress", 32'(memAddress[g]), 32'd0);
        end
        rst = '0;
        cycle();
        for (int g = 0; g < NCFG; g++) chk(g, "abort_release", 32'(reqReady[g]), 32'd1);

        // Randomized traffic with occasional resets and random backpressure
        for (int n = 0; n < NCYC_RAND; n++) begin
            for (int g = 0; g < NCFG; g++) begin
                rst[g]       = ($urandom_range(0, 99) < 2);
                reqValid[g]  = 1'($urandom_range(0, 1));
                reqWrite[g]  = 1'($urandom_range(0, 1));
                reqAddr[g]   = pick_addr();
                reqData[g]   = W'($urandom);
                respReady[g] = ($urandom_range(0, 9) < 6);
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/risc16_mem_requester.md
Name: risc16_mem_requester

Overview:
Initiator-side controller for the single-port RiSC16 word memory (address/dataIn/writeEn in, dataOut out). It accepts one load or store request at a time from the core over a valid/ready handshake and sequences the memory-side signals. It waits out the memory read latency and returns read data or a write acknowledgement over a response handshake. It sits between the datapath load/store logic and the memory instance.

Parameters:
WORD_LENGTH, 16, data and address width in bits.
MEM_SIZE, 65536, number of implemented words; requests with address >= MEM_SIZE are rejected with an error.
READ_LATENCY, 0, cycles after the address is presented before memory dataOut is valid; legal range 0..7. 0 means combinational read.

Ports:
clk  input  1  clock; all state changes on the rising edge.
rst  input  1  synchronous, active-high reset.
reqValid  input  1  request present.
reqReady  output  1  block can accept a request.
reqWrite  input  1  1 = store, 0 = load.
reqAddr  input  WORD_LENGTH  word address.
reqData  input  WORD_LENGTH  store data.
respValid  output  1  response present.
respReady  input  1  consumer accepts the response.
respData  output  WORD_LENGTH  load data; 0 for stores and errors.
respErr  output  1  address out of range.
memAddress  output  WORD_LENGTH  to memory address.
memDataIn  output  WORD_LENGTH  to memory dataIn.
memWriteEn  output  1  to memory writeEn.
memDataOut  input  WORD_LENGTH  from memory dataOut.

Behaviour:
- Reset (rst high at an edge): state IDLE. memAddress=0, memDataIn=0, memWriteEn=0, respValid=0, respData=0, respErr=0, latency counter=0. reqReady=0 while rst is high.
- States: IDLE, WRITE, READ, RESP.
- IDLE: reqReady=1 (combinational from state, gated by ~rst). Handshake = reqValid & reqReady at an edge.
  - Accept, addr < MEM_SIZE, write: latch memAddress=reqAddr, memDataIn=reqData, memWriteEn=1; go to WRITE.
  - Accept, addr < MEM_SIZE, read: latch memAddress=reqAddr, memWriteEn=0, counter=0; go to READ.
  - Accept, addr >= MEM_SIZE: no memory access, memWriteEn stays 0. Go to RESP with respErr=1, respData=0.
- WRITE: lasts exactly 1 cycle. memWriteEn=1, so memory commits at the edge ending this cycle. At that edge: memWriteEn<=0, respValid<=1, respData<=0, respErr<=0; go to RESP.
- READ: lasts READ_LATENCY+1 cycles, with memAddress stable throughout. The counter increments each cycle. At the edge where counter==READ_LATENCY: respData<=memDataOut, respValid<=1, respErr<=0; go to RESP.
- RESP: respValid, respData and respErr are held stable until respValid & respReady at an edge. At that edge: respValid<=0, respErr<=0; go to IDLE.
  - reqReady rises the cycle after the response handshake; there is no same-cycle overlap.
- Latency from the accept edge to respValid high: write 1 cycle; read READ_LATENCY+1 cycles; error 1 cycle.
- reqValid or reqData changes while not IDLE are ignored; no request is queued.
- memAddress and memDataIn retain their last values in IDLE and RESP. memWriteEn is 1 only in WRITE.
- respReady held high with no pending response has no effect.
- Reset mid-operation (any state): abort at that edge. memWriteEn is 0 from the next cycle. No response is issued for the aborted request.
  - A write in progress in WRITE still commits at the reset edge, because memory sees writeEn=1 at that edge.
- Address comparison is unsigned. With MEM_SIZE=65536 no 16-bit address is out of range.

Test Plan:
- Write then read, READ_LATENCY=0: store 0x2000 at 0x1222 -> memWriteEn high for exactly 1 cycle with memAddress=0x1222, memDataIn=0x2000; ack respValid=1, respData=0. Load 0x1222 -> respData=0x2000 one cycle after accept.
- READ_LATENCY=3 with a memory model of latency 3: load 0x0005 holding 0xBEEF -> respValid rises 4 cycles after accept, respData=0xBEEF. memAddress is stable for all 4 READ cycles.
- Backpressure: hold respReady=0 for 5 cycles after a load of 0x00A0 (data 0x1234) -> respValid and respData=0x1234 held for all 5 cycles, reqReady=0. Raise respReady -> IDLE next cycle, reqReady=1.
- Out of range, MEM_SIZE=4096: store to 0x1000 -> memWriteEn never asserts; respValid with respErr=1, respData=0. A subsequent load of 0x0FFF proceeds normally with respErr=0.
- Reset mid-read, READ_LATENCY=5: assert rst 2 cycles after accept -> respValid never rises. All outputs return to 0 and reqReady=0 during rst, then 1 the cycle after rst is released.
- Busy rejection: pulse reqValid with store 0xFFFF to 0x0001 while in READ -> no memWriteEn pulse and no extra response. Read back 0x0001 to confirm it is unchanged.
